// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchronizer, symmetric debounce FSM and a
// saturating hold timer that flags a long press.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned HOLD_CYCLES     = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_hold
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HCNT_MAX = HW'(HOLD_CYCLES);

   localparam logic [1:0] S_LOW       = 2'd0;
   localparam logic [1:0] S_WAIT_HIGH = 2'd1;
   localparam logic [1:0] S_HIGH      = 2'd2;
   localparam logic [1:0] S_WAIT_LOW  = 2'd3;

   logic          r_sync1;
   logic          r_sync2;
   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [HW-1:0] r_hcnt;
   logic          r_level;
   logic          r_hold;

   logic [1:0]    w_state_d;
   logic [CW-1:0] w_cnt_d;
   logic [HW-1:0] w_hcnt_d;
   logic          w_level_d;
   logic          w_hold_d;

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      case (r_state)
         S_LOW: begin
            if (r_sync2) begin
               w_state_d = S_WAIT_HIGH;
               w_cnt_d   = CW'(1);
            end else begin
               w_cnt_d = '0;
            end
         end
         S_WAIT_HIGH: begin
            if (!r_sync2) begin
               w_state_d = S_LOW;
               w_cnt_d   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_d = S_HIGH;
               w_cnt_d   = '0;
            end else begin
               w_cnt_d = r_cnt + CW'(1);
            end
         end
         S_HIGH: begin
            if (!r_sync2) begin
               w_state_d = S_WAIT_LOW;
               w_cnt_d   = CW'(1);
            end else begin
               w_cnt_d = '0;
            end
         end
         S_WAIT_LOW: begin
            if (r_sync2) begin
               w_state_d = S_HIGH;
               w_cnt_d   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_d = S_LOW;
               w_cnt_d   = '0;
            end else begin
               w_cnt_d = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_d = S_LOW;
            w_cnt_d   = '0;
         end
      endcase
   end

   // Level is decoded from the next state so it flips on the same edge as the FSM.
   always_comb begin
      w_level_d = (w_state_d == S_HIGH) || (w_state_d == S_WAIT_LOW);
      if (!r_level) begin
         w_hcnt_d = '0;
      end else if (r_hcnt == HCNT_MAX) begin
         w_hcnt_d = r_hcnt;
      end else begin
         w_hcnt_d = r_hcnt + HW'(1);
      end
      w_hold_d = w_level_d && (w_hcnt_d == HCNT_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_state <= S_LOW;
         r_cnt   <= '0;
         r_hcnt  <= '0;
         r_level <= 1'b0;
         r_hold  <= 1'b0;
      end else begin
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_hcnt  <= w_hcnt_d;
         r_level <= w_level_d;
         r_hold  <= w_hold_d;
      end
   end

   assign btn_level = r_level;
   assign btn_hold  = r_hold;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10;
// expected outputs are written as edge windows relative to each reset release.
module tb_button_conditioner;

   localparam int NEVER = 100000;

   logic clk;
   logic rst;
   logic btn_raw;
   logic btn_level;
   logic btn_hold;

   int edge_n;
   int n_checks;
   int n_pass;

   button_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES    (10)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw),
      .btn_level(btn_level),
      .btn_hold (btn_hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s @edge %0d: got %b expected %b", tag, edge_n, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   // Tick up to edge 'upto', checking both outputs against their expected windows.
   task automatic span(input int upto, input int lvl_rise, input int lvl_fall,
                       input int hold_rise);
      while (edge_n < upto) begin
         tick();
         check("level", btn_level, (edge_n >= lvl_rise) && (edge_n < lvl_fall));
         check("hold", btn_hold, (edge_n >= hold_rise) && (edge_n < lvl_fall));
      end
   endtask

   task automatic restart();
      rst     = 1'b1;
      btn_raw = 1'b0;
      #1;
      check("rst_level", btn_level, 1'b0);
      check("rst_hold", btn_hold, 1'b0);
      repeat (3) tick();
      rst    = 1'b0;
      edge_n = 0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      edge_n   = 0;
      rst      = 1'b1;
      btn_raw  = 1'b0;

      // Clean press, then release with one bounce.
      restart();
      span(9, NEVER, NEVER, NEVER);
      btn_raw = 1'b1;
      span(46, 15, NEVER, 25);
      btn_raw = 1'b0;
      span(48, 15, 55, 25);
      btn_raw = 1'b1;
      span(49, 15, 55, 25);
      btn_raw = 1'b0;
      span(62, 15, 55, 25);

      // Bounce on press: 3 high, 1 low, then steady high from edge 20.
      restart();
      span(15, NEVER, NEVER, NEVER);
      btn_raw = 1'b1;
      span(18, NEVER, NEVER, NEVER);
      btn_raw = 1'b0;
      span(19, NEVER, NEVER, NEVER);
      btn_raw = 1'b1;
      span(30, 25, NEVER, NEVER);

      // Glitches of 1 and 3 cycles.
      restart();
      span(9, NEVER, NEVER, NEVER);
      btn_raw = 1'b1;
      span(10, NEVER, NEVER, NEVER);
      btn_raw = 1'b0;
      span(24, NEVER, NEVER, NEVER);
      btn_raw = 1'b1;
      span(27, NEVER, NEVER, NEVER);
      btn_raw = 1'b0;
      span(40, NEVER, NEVER, NEVER);

      // Reset during the rising count; release before edge 12 with button held.
      restart();
      span(4, NEVER, NEVER, NEVER);
      btn_raw = 1'b1;
      span(8, NEVER, NEVER, NEVER);
      rst = 1'b1;
      span(11, NEVER, NEVER, NEVER);
      rst = 1'b0;
      span(30, 17, NEVER, 27);

      // Asynchronous reset mid-cycle while level and hold are high.
      #2;
      rst = 1'b1;
      #1;
      check("async_level", btn_level, 1'b0);
      check("async_hold", btn_hold, 1'b0);
      span(33, NEVER, NEVER, NEVER);
      btn_raw = 1'b0;
      rst     = 1'b0;
      span(42, NEVER, NEVER, NEVER);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
